// File: rtl/dcw_link_sequencer.sv
// Bring-up sequencer for the data channel wrapper: reset, run at the primary width,
// optionally switch to the secondary width, and report done/error with a cause code.
module dcw_link_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int TW           = 11
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] width_a,
  input  logic [2:0] width_b,
  input  logic       switch_en,
  input  logic       chan_ready,
  output logic [2:0] ctrl_sig,
  output logic [2:0] val,
  output logic [2:0] val1,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN_A,
    S_RUN_B,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] ERR_WIDTH   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;

  state_t        state, state_d;
  logic [TW-1:0] timer, timer_d, timer_inc;
  logic          sw, sw_d;
  logic [2:0]    ctrl_d, val_d, val1_d;
  logic          busy_d, done_d, error_d;
  logic [1:0]    err_code_d;
  logic          go_err, go_done, illegal;
  logic [1:0]    err_cause;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      timer    <= '0;
      sw       <= 1'b0;
      ctrl_sig <= 3'd0;
      val      <= 3'd0;
      val1     <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= 2'b00;
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      sw       <= sw_d;
      ctrl_sig <= ctrl_d;
      val      <= val_d;
      val1     <= val1_d;
      busy     <= busy_d;
      done     <= done_d;
      error    <= error_d;
      err_code <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state;
    timer_d    = timer;
    sw_d       = sw;
    ctrl_d     = ctrl_sig;
    val_d      = val;
    val1_d     = val1;
    busy_d     = busy;
    done_d     = done;
    error_d    = error;
    err_code_d = err_code;
    go_err     = 1'b0;
    go_done    = 1'b0;
    err_cause  = 2'b00;
    // Saturating increment so a stalled timer can never wrap back into range.
    timer_inc  = (timer == '1) ? timer : timer + 1'b1;
    illegal    = (width_a == 3'd0) || (switch_en && (width_b == 3'd0));

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          if (illegal) begin
            go_err    = 1'b1;
            err_cause = ERR_WIDTH;
          end else begin
            state_d    = S_RESET;
            timer_d    = '0;
            sw_d       = switch_en;
            val_d      = width_a;
            val1_d     = width_b;
            ctrl_d     = 3'd1;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            error_d    = 1'b0;
            err_code_d = 2'b00;
          end
        end
      end
      S_RESET: begin
        if (abort) begin
          go_err    = 1'b1;
          err_cause = ERR_ABORT;
        end else if (timer == RST_LAST) begin
          state_d = S_RUN_A;
          timer_d = '0;
          ctrl_d  = 3'd2;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_RUN_A: begin
        if (abort) begin
          go_err    = 1'b1;
          err_cause = ERR_ABORT;
        end else if (chan_ready) begin
          if (sw) begin
            state_d = S_RUN_B;
            timer_d = '0;
            ctrl_d  = 3'd3;
          end else begin
            go_done = 1'b1;
          end
        end else if (timer == LOCK_LAST) begin
          go_err    = 1'b1;
          err_cause = ERR_TIMEOUT;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_RUN_B: begin
        // Ready is not trusted in the first cycle after the width change.
        if (abort) begin
          go_err    = 1'b1;
          err_cause = ERR_ABORT;
        end else if (chan_ready && (timer != '0)) begin
          go_done = 1'b1;
        end else if (timer == LOCK_LAST) begin
          go_err    = 1'b1;
          err_cause = ERR_TIMEOUT;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        ctrl_d  = 3'd0;
        busy_d  = 1'b0;
      end
    endcase

    if (go_done) begin
      state_d = S_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
    // Error keeps the channel held in reset until the next accepted start.
    if (go_err) begin
      state_d    = S_ERR;
      ctrl_d     = 3'd1;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      error_d    = 1'b1;
      err_code_d = err_cause;
    end
  end

endmodule

// File: tb/tb_dcw_link_sequencer.sv
// Directed bench for dcw_link_sequencer: inputs change and outputs are checked
// on the falling edge, half a cycle away from the rising edge the DUT uses.
module tb_dcw_link_sequencer;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [2:0] width_a;
  logic [2:0] width_b;
  logic       switch_en;
  logic       chan_ready;
  logic [2:0] ctrl_sig;
  logic [2:0] val;
  logic [2:0] val1;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  int n_cmp = 0;
  int n_bad = 0;

  dcw_link_sequencer #(
    .RST_CYCLES  (16),
    .LOCK_TIMEOUT(1024),
    .TW          (11)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .width_a   (width_a),
    .width_b   (width_b),
    .switch_en (switch_en),
    .chan_ready(chan_ready),
    .ctrl_sig  (ctrl_sig),
    .val       (val),
    .val1      (val1),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    width_a    = 3'd0;
    width_b    = 3'd0;
    switch_en  = 1'b0;
    chan_ready = 1'b0;
    step(2);

    chk("rst_ctrl", ctrl_sig, 0);
    chk("rst_val", val, 0);
    chk("rst_val1", val1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    reset_n = 1'b1;
    step(1);

    // T1: single width, ready arrives in RUN_A cycle 5
    width_a   = 3'd3;
    switch_en = 1'b0;
    pulse_start();
    chk("t1_busy_after_start", busy, 1);
    for (int i = 0; i < 16; i++) begin
      chk("t1_reset_ctrl", ctrl_sig, 1);
      step(1);
    end
    for (int i = 0; i < 6; i++) begin
      chk("t1_runa_ctrl", ctrl_sig, 2);
      chk("t1_runa_done", done, 0);
      if (i == 5) chan_ready = 1'b1;
      step(1);
    end
    chan_ready = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_done_busy", busy, 0);
    chk("t1_done_ctrl", ctrl_sig, 2);
    chk("t1_val", val, 3);
    step(3);
    chk("t1_ctrl_hold", ctrl_sig, 2);

    // T2: width switch, ready already high when RUN_B is entered
    width_a   = 3'd2;
    width_b   = 3'd4;
    switch_en = 1'b1;
    pulse_start();
    chk("t2_done_cleared", done, 0);
    chk("t2_reset_ctrl", ctrl_sig, 1);
    step(16);
    chk("t2_runa_ctrl", ctrl_sig, 2);
    chan_ready = 1'b1;
    step(1);
    chk("t2_runb_ctrl", ctrl_sig, 3);
    chk("t2_runb_c0_done", done, 0);
    step(1);
    chk("t2_runb_c1_done", done, 0);
    chk("t2_runb_c1_busy", busy, 1);
    step(1);
    chk("t2_done", done, 1);
    chk("t2_done_ctrl", ctrl_sig, 3);
    chk("t2_val", val, 2);
    chk("t2_val1", val1, 4);
    chan_ready = 1'b0;

    // T3: ready never comes -> timeout after 1024 RUN_A cycles
    width_a   = 3'd1;
    switch_en = 1'b0;
    pulse_start();
    step(16);
    chk("t3_runa_ctrl", ctrl_sig, 2);
    step(1023);
    chk("t3_last_runa_ctrl", ctrl_sig, 2);
    chk("t3_last_runa_error", error, 0);
    step(1);
    chk("t3_error", error, 1);
    chk("t3_err_code", err_code, 2);
    chk("t3_err_ctrl", ctrl_sig, 1);
    chk("t3_err_busy", busy, 0);

    // T4: illegal width, then a legal restart from ERR
    width_a = 3'd0;
    pulse_start();
    chk("t4_error", error, 1);
    chk("t4_err_code", err_code, 1);
    chk("t4_ctrl", ctrl_sig, 1);
    chk("t4_val_kept", val, 1);
    width_a = 3'd5;
    pulse_start();
    chk("t4_restart_error", error, 0);
    chk("t4_restart_err_code", err_code, 0);
    chk("t4_restart_busy", busy, 1);
    chk("t4_restart_val", val, 5);

    // T5: abort in RESET cycle 7 beats a simultaneous ready
    step(7);
    chk("t5_reset_ctrl", ctrl_sig, 1);
    abort      = 1'b1;
    chan_ready = 1'b1;
    step(1);
    abort      = 1'b0;
    chan_ready = 1'b0;
    chk("t5_error", error, 1);
    chk("t5_err_code", err_code, 3);
    chk("t5_busy", busy, 0);

    // T6: asynchronous reset during RUN_B, abort in IDLE, full rerun
    width_a   = 3'd2;
    width_b   = 3'd6;
    switch_en = 1'b1;
    pulse_start();
    step(16);
    chan_ready = 1'b1;
    step(1);
    chan_ready = 1'b0;
    chk("t6_runb_ctrl", ctrl_sig, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_ctrl", ctrl_sig, 0);
    chk("t6_async_val", val, 0);
    chk("t6_async_val1", val1, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_error", error, 0);
    step(1);
    reset_n = 1'b1;
    abort   = 1'b1;
    step(2);
    abort = 1'b0;
    chk("t6_idle_abort_ctrl", ctrl_sig, 0);
    chk("t6_idle_abort_error", error, 0);
    chk("t6_idle_abort_code", err_code, 0);
    width_a   = 3'd3;
    switch_en = 1'b0;
    pulse_start();
    chk("t6_rerun_ctrl", ctrl_sig, 1);
    step(15);
    chk("t6_rerun_reset_end", ctrl_sig, 1);
    step(1);
    chk("t6_rerun_runa", ctrl_sig, 2);
    chan_ready = 1'b1;
    step(1);
    chan_ready = 1'b0;
    chk("t6_rerun_done", done, 1);
    chk("t6_rerun_val", val, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
